// File: rtl/vtg_mode_ctrl.sv
// Run-time mode controller for the video timing generator: a 4-entry timing table,
// frame-aligned mode switching with a watchdog, VTG reset hold and settle-to-lock.
module vtg_mode_ctrl #(
  parameter int X_BITS         = 12,
  parameter int Y_BITS         = 12,
  parameter int INIT_MODE      = 0,
  parameter int HOLD_CYCLES    = 16,
  parameter int SETTLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_mode,
  output logic              req_ready,
  input  logic              frame_end,
  output logic              tg_rstn,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_fp,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] h_act,
  output logic [Y_BITS-1:0] v_total,
  output logic [Y_BITS-1:0] v_fp,
  output logic [Y_BITS-1:0] v_bp,
  output logic [Y_BITS-1:0] v_sync,
  output logic [Y_BITS-1:0] v_act,
  output logic [1:0]        cur_mode,
  output logic              locked,
  output logic              chg_done,
  output logic              err_timeout
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_FRAMES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    INIT_M      = 2'(INIT_MODE);

  // Columns: total, fp, bp, sync, act
  localparam logic [15:0] H_TAB [4][5] = '{
    '{16'd1650, 16'd110, 16'd220, 16'd40,  16'd1280},
    '{16'd2200, 16'd88,  16'd148, 16'd44,  16'd1920},
    '{16'd800,  16'd16,  16'd48,  16'd96,  16'd640},
    '{16'd1344, 16'd24,  16'd160, 16'd136, 16'd1024}
  };
  localparam logic [15:0] V_TAB [4][5] = '{
    '{16'd750,  16'd5,  16'd20, 16'd5, 16'd720},
    '{16'd1125, 16'd4,  16'd36, 16'd5, 16'd1080},
    '{16'd525,  16'd10, 16'd33, 16'd2, 16'd480},
    '{16'd806,  16'd3,  16'd29, 16'd6, 16'd768}
  };

  // HOLD: VTG in reset | SETTLE: released, counting frames | RUN: locked, accepting | WAIT_EOF: draining old frame
  typedef enum logic [1:0] {S_HOLD, S_SETTLE, S_RUN, S_WAIT_EOF} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   settle_cnt;
  logic [TW-1:0]   to_cnt;
  logic [1:0]      pend_mode;
  logic            chg_pend;

  logic            accept, load;
  logic            tg_rstn_d, locked_d, ready_d, done_d, err_d, chg_pend_d;
  logic [1:0]      mode_d;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HOLD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD:     if (hold_cnt == HOLD_LAST) state_d = S_SETTLE;
      S_SETTLE:   if (frame_end && settle_cnt == SETTLE_LAST) state_d = S_RUN;
      S_RUN:      if (accept && req_mode != cur_mode) state_d = S_WAIT_EOF;
      S_WAIT_EOF: if (frame_end || to_cnt == TO_LAST) state_d = S_HOLD;
      default:    state_d = S_HOLD;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    load       = (state_q == S_WAIT_EOF) && (state_d == S_HOLD);
    tg_rstn_d  = (state_d != S_HOLD);
    locked_d   = (state_d == S_RUN) || (state_d == S_WAIT_EOF);
    ready_d    = (state_d == S_RUN);
    done_d     = ((state_q == S_SETTLE) && (state_d == S_RUN) && chg_pend) ||
                 (accept && req_mode == cur_mode);
    chg_pend_d = chg_pend;
    if (accept && req_mode != cur_mode)            chg_pend_d = 1'b1;
    if (state_q == S_SETTLE && state_d == S_RUN)   chg_pend_d = 1'b0;
    err_d = err_timeout;
    if (accept)             err_d = 1'b0;
    if (load && !frame_end) err_d = 1'b1;
    mode_d = cur_mode;
    if (rst)       mode_d = INIT_M;
    else if (load) mode_d = pend_mode;
  end

  always_ff @(posedge clk) begin
    if (rst || state_d != state_q) begin
      hold_cnt   <= '0;
      settle_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      if (state_q == S_HOLD)                 hold_cnt   <= hold_cnt + 1'b1;
      if (state_q == S_SETTLE && frame_end)  settle_cnt <= settle_cnt + 1'b1;
      if (state_q == S_WAIT_EOF)             to_cnt     <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tg_rstn     <= 1'b0;
      locked      <= 1'b0;
      req_ready   <= 1'b0;
      chg_done    <= 1'b0;
      err_timeout <= 1'b0;
      chg_pend    <= 1'b0;
      pend_mode   <= INIT_M;
    end else begin
      tg_rstn     <= tg_rstn_d;
      locked      <= locked_d;
      req_ready   <= ready_d;
      chg_done    <= done_d;
      err_timeout <= err_d;
      chg_pend    <= chg_pend_d;
      if (accept) pend_mode <= req_mode;
    end
  end

  // Parameter buses follow cur_mode, so they only move on reset or the WAIT_EOF->HOLD load.
  always_ff @(posedge clk) begin
    cur_mode <= mode_d;
    h_total  <= X_BITS'(H_TAB[mode_d][0]);
    h_fp     <= X_BITS'(H_TAB[mode_d][1]);
    h_bp     <= X_BITS'(H_TAB[mode_d][2]);
    h_sync   <= X_BITS'(H_TAB[mode_d][3]);
    h_act    <= X_BITS'(H_TAB[mode_d][4]);
    v_total  <= Y_BITS'(V_TAB[mode_d][0]);
    v_fp     <= Y_BITS'(V_TAB[mode_d][1]);
    v_bp     <= Y_BITS'(V_TAB[mode_d][2]);
    v_sync   <= Y_BITS'(V_TAB[mode_d][3]);
    v_act    <= Y_BITS'(V_TAB[mode_d][4]);
  end

endmodule
